// File: rtl/spi_arbiter.sv
// Two-requester round-robin arbiter in front of a single-byte SPI master core.
// The winner owns its slave select for a whole burst of 1..16 bytes.
module spi_arbiter #(
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [1:0]  req_i,
    input  logic [7:0]  len_i,
    output logic [1:0]  gnt_o,
    input  logic [15:0] tx_data_i,
    input  logic [1:0]  tx_valid_i,
    output logic [1:0]  tx_ready_o,
    output logic [7:0]  rx_data_o,
    output logic [1:0]  rx_valid_o,
    output logic [1:0]  done_o,
    output logic [7:0]  spi_din_o,
    output logic        spi_start_o,
    input  logic [7:0]  spi_dout_i,
    input  logic        spi_done_tick_i,
    input  logic        spi_ready_i,
    output logic [1:0]  ss_n_o
);

    localparam logic [3:0] SETUP_CNT = 4'(CS_SETUP);
    localparam logic [3:0] HOLD_CNT  = 4'(CS_HOLD);

    typedef enum logic [2:0] {IDLE, SETUP, LOAD, XFER, HOLD} state_t;

    state_t     state_reg;
    logic       sel_reg;
    logic       ptr_reg;
    logic [3:0] cnt_reg;
    logic [4:0] rem_reg;
    logic [1:0] gnt_reg;
    logic [1:0] ss_n_reg;
    logic [1:0] tx_ready_reg;
    logic [1:0] rx_valid_reg;
    logic [1:0] done_reg;
    logic       spi_start_reg;
    logic [7:0] spi_din_reg;
    logic [7:0] rx_data_reg;

    logic [4:0] len_bytes [2];
    logic [7:0] byte_arr  [2];

    // A length field of zero encodes a 16-byte burst.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_req
            assign len_bytes[gi] = (len_i[4*gi +: 4] == 4'd0) ? 5'd16 : {1'b0, len_i[4*gi +: 4]};
            assign byte_arr[gi]  = tx_data_i[8*gi +: 8];
        end
    endgenerate

    logic       win;
    logic [1:0] win_oh;
    logic [1:0] sel_oh;
    logic       handshake;

    always_comb begin
        win = req_i[1];
        if (req_i == 2'b11) begin
            win = ~ptr_reg;
        end
    end

    assign win_oh    = win ? 2'b10 : 2'b01;
    assign sel_oh    = sel_reg ? 2'b10 : 2'b01;
    assign handshake = |(tx_valid_i & tx_ready_reg & sel_oh);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg     <= IDLE;
            sel_reg       <= 1'b0;
            ptr_reg       <= 1'b1;
            cnt_reg       <= '0;
            rem_reg       <= '0;
            gnt_reg       <= '0;
            ss_n_reg      <= 2'b11;
            tx_ready_reg  <= '0;
            rx_valid_reg  <= '0;
            done_reg      <= '0;
            spi_start_reg <= 1'b0;
            spi_din_reg   <= '0;
            rx_data_reg   <= '0;
        end else begin
            spi_start_reg <= 1'b0;
            rx_valid_reg  <= '0;
            done_reg      <= '0;
            case (state_reg)
                IDLE: begin
                    if (|req_i) begin
                        sel_reg   <= win;
                        rem_reg   <= len_bytes[win];
                        gnt_reg   <= win_oh;
                        ss_n_reg  <= ~win_oh;
                        cnt_reg   <= SETUP_CNT;
                        state_reg <= SETUP;
                    end
                end
                SETUP: begin
                    if (cnt_reg > 4'd1) begin
                        cnt_reg <= cnt_reg - 4'd1;
                    end else if (spi_ready_i) begin
                        tx_ready_reg <= sel_oh;
                        state_reg    <= LOAD;
                    end
                end
                LOAD: begin
                    if (handshake) begin
                        spi_din_reg   <= byte_arr[sel_reg];
                        spi_start_reg <= 1'b1;
                        tx_ready_reg  <= '0;
                        state_reg     <= XFER;
                    end else begin
                        tx_ready_reg <= spi_ready_i ? sel_oh : 2'b00;
                    end
                end
                XFER: begin
                    if (spi_done_tick_i) begin
                        rx_data_reg  <= spi_dout_i;
                        rx_valid_reg <= sel_oh;
                        rem_reg      <= rem_reg - 5'd1;
                        if (rem_reg == 5'd1) begin
                            cnt_reg   <= HOLD_CNT;
                            state_reg <= HOLD;
                        end else begin
                            tx_ready_reg <= spi_ready_i ? sel_oh : 2'b00;
                            state_reg    <= LOAD;
                        end
                    end
                end
                HOLD: begin
                    if (cnt_reg > 4'd1) begin
                        cnt_reg <= cnt_reg - 4'd1;
                    end else begin
                        // Returning through IDLE guarantees one all-deselected cycle between bursts.
                        ss_n_reg  <= 2'b11;
                        gnt_reg   <= '0;
                        done_reg  <= sel_oh;
                        ptr_reg   <= sel_reg;
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign gnt_o       = gnt_reg;
    assign ss_n_o      = ss_n_reg;
    assign tx_ready_o  = tx_ready_reg;
    assign rx_valid_o  = rx_valid_reg;
    assign done_o      = done_reg;
    assign spi_start_o = spi_start_reg;
    assign spi_din_o   = spi_din_reg;
    assign rx_data_o   = rx_data_reg;

endmodule

// File: tb/tb_spi_arbiter.sv
// Directed bench for spi_arbiter with a behavioural SPI core that answers
// each byte with (byte ^ 8'h99) a few cycles after its start pulse.
module tb_spi_arbiter;

    localparam int CS_SETUP = 2;
    localparam int CS_HOLD  = 2;

    logic        clk_i      = 1'b0;
    logic        rst_ni     = 1'b0;
    logic [1:0]  req_i      = '0;
    logic [7:0]  len_i      = '0;
    logic [15:0] tx_data_i  = '0;
    logic [1:0]  tx_valid_i = '0;
    logic [7:0]  spi_dout_i = '0;
    logic        spi_done_tick_i;
    logic        spi_ready_i;
    logic [1:0]  gnt_o, tx_ready_o, rx_valid_o, done_o, ss_n_o;
    logic [7:0]  rx_data_o, spi_din_o;
    logic        spi_start_o;

    int errors = 0;
    int checks = 0;

    spi_arbiter #(.CS_SETUP(CS_SETUP), .CS_HOLD(CS_HOLD)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i), .len_i(len_i), .gnt_o(gnt_o),
        .tx_data_i(tx_data_i), .tx_valid_i(tx_valid_i), .tx_ready_o(tx_ready_o),
        .rx_data_o(rx_data_o), .rx_valid_o(rx_valid_o), .done_o(done_o),
        .spi_din_o(spi_din_o), .spi_start_o(spi_start_o), .spi_dout_i(spi_dout_i),
        .spi_done_tick_i(spi_done_tick_i), .spi_ready_i(spi_ready_i), .ss_n_o(ss_n_o)
    );

    always #5 clk_i = ~clk_i;

    // SPI core model
    logic       core_busy  = 1'b0;
    int         core_cnt   = 0;
    logic       core_tick  = 1'b0;
    logic [7:0] core_byte  = '0;
    logic       tb_unready = 1'b0;
    logic       tb_tick    = 1'b0;

    assign spi_ready_i     = !core_busy && !tb_unready;
    assign spi_done_tick_i = core_tick | tb_tick;

    always @(posedge clk_i) begin
        core_tick <= 1'b0;
        if (core_busy) begin
            if (core_cnt == 0) begin
                core_tick  <= 1'b1;
                spi_dout_i <= core_byte ^ 8'h99;
                core_busy  <= 1'b0;
            end else begin
                core_cnt <= core_cnt - 1;
            end
        end else if (spi_start_o) begin
            core_busy <= 1'b1;
            core_cnt  <= 2;
            core_byte <= spi_din_o;
        end
    end

    // Event monitor, sampled on the falling edge
    int         cyc = 0;
    int         start_cnt = 0, viol = 0, grant_n = 0;
    int         rxv_cnt [2];
    int         done_cnt [2];
    int         ss_fall_cyc [2];
    int         ss_rise_cyc [2];
    int         last_start_cyc = 0, last_tick_cyc = 0;
    logic [7:0] last_din = '0, last_rx = '0;
    logic [1:0] prev_ss = 2'b11, prev_gnt = 2'b00;
    logic       prev_start = 1'b0;
    logic       grant_hist [64];

    always @(posedge clk_i) cyc <= cyc + 1;

    always @(negedge clk_i) begin
        if (spi_start_o) begin
            start_cnt      <= start_cnt + 1;
            last_start_cyc <= cyc;
            last_din       <= spi_din_o;
        end
        if (spi_done_tick_i) last_tick_cyc <= cyc;
        if (|rx_valid_o) last_rx <= rx_data_o;
        for (int k = 0; k < 2; k++) begin
            if (rx_valid_o[k]) rxv_cnt[k] <= rxv_cnt[k] + 1;
            if (done_o[k]) done_cnt[k] <= done_cnt[k] + 1;
            if (prev_ss[k] && !ss_n_o[k]) ss_fall_cyc[k] <= cyc;
            if (!prev_ss[k] && ss_n_o[k]) ss_rise_cyc[k] <= cyc;
        end
        if (prev_gnt == 2'b00 && gnt_o != 2'b00 && grant_n < 64) begin
            grant_hist[grant_n[5:0]] <= gnt_o[1];
            grant_n <= grant_n + 1;
        end
        if ((ss_n_o == 2'b00) || (prev_start && spi_start_o) || (gnt_o != ~ss_n_o) ||
            (((tx_ready_o | rx_valid_o) & ~gnt_o) != 2'b00) ||
            (ss_n_o != prev_ss && ss_n_o != 2'b11 && prev_ss != 2'b11))
            viol <= viol + 1;
        prev_ss    <= ss_n_o;
        prev_gnt   <= gnt_o;
        prev_start <= spi_start_o;
    end

    task automatic wait_gnt(input int n, input int budget, output bit to);
        to = 1'b1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk_i);
            if (gnt_o[n[0]]) begin to = 1'b0; break; end
        end
    endtask

    task automatic wait_done(input int n, input int budget, output bit to);
        to = 1'b1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk_i);
            if (done_o[n[0]]) begin to = 1'b0; break; end
        end
    endtask

    task automatic wait_ready(input int n, input int budget, output bit to);
        to = 1'b1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk_i);
            if (tx_ready_o[n[0]]) begin to = 1'b0; break; end
        end
    endtask

    task automatic do_reset();
        rst_ni = 1'b0; req_i = '0; tx_valid_i = '0; tb_unready = 1'b0; tb_tick = 1'b0;
        repeat (2) @(posedge clk_i);
        #1 rst_ni = 1'b1;
        @(posedge clk_i); #1;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        repeat (3) @(negedge clk_i);
        checks++; if (ss_n_o !== 2'b11) begin errors++; $display("FAIL reset_ss_n: got %b want 11", ss_n_o); end
        checks++; if (gnt_o !== 2'b00) begin errors++; $display("FAIL reset_gnt: got %b want 00", gnt_o); end
        checks++; if ({tx_ready_o, rx_valid_o, done_o} !== 6'b0) begin errors++; $display("FAIL reset_handshake: got %b want 0", {tx_ready_o, rx_valid_o, done_o}); end
        checks++; if (spi_start_o !== 1'b0) begin errors++; $display("FAIL reset_start: got %b want 0", spi_start_o); end
        checks++; if (spi_din_o !== 8'h00) begin errors++; $display("FAIL reset_din: got %h want 00", spi_din_o); end
        checks++; if (rx_data_o !== 8'h00) begin errors++; $display("FAIL reset_rx_data: got %h want 00", rx_data_o); end
        @(posedge clk_i); #1 rst_ni = 1'b1;
        repeat (3) @(negedge clk_i);
        checks++; if ({ss_n_o, gnt_o} !== 4'b1100) begin errors++; $display("FAIL reset_idle: got %b want 1100", {ss_n_o, gnt_o}); end
        $display("test_reset done");
    endtask

    task automatic test_single();
        int s_start, s_rx0, s_rx1, s_d0, s_d1, s_viol, lat;
        bit to;
        @(posedge clk_i); #1;
        s_start = start_cnt; s_rx0 = rxv_cnt[0]; s_rx1 = rxv_cnt[1];
        s_d0 = done_cnt[0]; s_d1 = done_cnt[1]; s_viol = viol;
        len_i = 8'h01; tx_data_i = 16'h00A5; tx_valid_i = 2'b01; req_i = 2'b01;
        wait_gnt(0, 20, to);
        checks++; if (to !== 1'b0) begin errors++; $display("FAIL single_grant: timed out waiting for gnt_o[0]"); end
        req_i = 2'b00;
        checks++; if (ss_n_o !== 2'b10) begin errors++; $display("FAIL single_ss_n: got %b want 10", ss_n_o); end
        wait_done(0, 200, to);
        checks++; if (to !== 1'b0) begin errors++; $display("FAIL single_done: timed out waiting for done_o[0]"); end
        checks++; if (ss_n_o !== 2'b11) begin errors++; $display("FAIL single_ss_at_done: got %b want 11", ss_n_o); end
        @(posedge clk_i); #1;
        checks++; if (start_cnt - s_start !== 1) begin errors++; $display("FAIL single_starts: got %0d want 1", start_cnt - s_start); end
        checks++; if (last_din !== 8'hA5) begin errors++; $display("FAIL single_din: got %h want a5", last_din); end
        checks++; if (last_rx !== 8'h3C) begin errors++; $display("FAIL single_rx: got %h want 3c", last_rx); end
        checks++; if ({rxv_cnt[0] - s_rx0, rxv_cnt[1] - s_rx1} !== {32'd1, 32'd0}) begin errors++; $display("FAIL single_rx_valid: got %0d/%0d want 1/0", rxv_cnt[0] - s_rx0, rxv_cnt[1] - s_rx1); end
        checks++; if ({done_cnt[0] - s_d0, done_cnt[1] - s_d1} !== {32'd1, 32'd0}) begin errors++; $display("FAIL single_done_cnt: got %0d/%0d want 1/0", done_cnt[0] - s_d0, done_cnt[1] - s_d1); end
        lat = last_start_cyc - ss_fall_cyc[0];
        checks++; if (lat < CS_SETUP || lat > CS_SETUP + 1) begin errors++; $display("FAIL single_setup: got %0d cycles want %0d..%0d", lat, CS_SETUP, CS_SETUP + 1); end
        lat = ss_rise_cyc[0] - last_tick_cyc;
        checks++; if (lat < CS_HOLD || lat > CS_HOLD + 1) begin errors++; $display("FAIL single_hold: got %0d cycles want %0d..%0d", lat, CS_HOLD, CS_HOLD + 1); end
        checks++; if (viol - s_viol !== 0) begin errors++; $display("FAIL single_protocol: got %0d violations want 0", viol - s_viol); end
        tx_valid_i = 2'b00;
        $display("test_single done");
    endtask

    task automatic test_tie();
        int s_start, s_rx0, s_rx1, s_d0, s_d1, s_viol, g0;
        bit to;
        do_reset();
        s_start = start_cnt; s_rx0 = rxv_cnt[0]; s_rx1 = rxv_cnt[1];
        s_d0 = done_cnt[0]; s_d1 = done_cnt[1]; s_viol = viol; g0 = grant_n;
        len_i = 8'h22; tx_data_i = 16'h5B1A; tx_valid_i = 2'b11; req_i = 2'b11;
        wait_gnt(0, 20, to);
        checks++; if (to !== 1'b0) begin errors++; $display("FAIL tie_grant0: timed out waiting for gnt_o[0]"); end
        checks++; if (gnt_o !== 2'b01) begin errors++; $display("FAIL tie_winner: got %b want 01", gnt_o); end
        req_i = 2'b10;
        wait_done(0, 300, to);
        checks++; if (to !== 1'b0) begin errors++; $display("FAIL tie_done0: timed out waiting for done_o[0]"); end
        checks++; if (ss_n_o !== 2'b11) begin errors++; $display("FAIL tie_idle_gap: got %b want 11", ss_n_o); end
        @(posedge clk_i); #1;
        checks++; if (start_cnt - s_start !== 2) begin errors++; $display("FAIL tie_starts0: got %0d want 2", start_cnt - s_start); end
        wait_gnt(1, 20, to);
        checks++; if (to !== 1'b0) begin errors++; $display("FAIL tie_grant1: timed out waiting for gnt_o[1]"); end
        req_i = 2'b00;
        wait_done(1, 300, to);
        checks++; if (to !== 1'b0) begin errors++; $display("FAIL tie_done1: timed out waiting for done_o[1]"); end
        @(posedge clk_i); #1;
        checks++; if ({grant_hist[g0[5:0]], grant_hist[6'(g0 + 1)]} !== 2'b01) begin errors++; $display("FAIL tie_order: got %b%b want 01", grant_hist[g0[5:0]], grant_hist[6'(g0 + 1)]); end
        checks++; if (start_cnt - s_start !== 4) begin errors++; $display("FAIL tie_starts: got %0d want 4", start_cnt - s_start); end
        checks++; if ({rxv_cnt[0] - s_rx0, rxv_cnt[1] - s_rx1} !== {32'd2, 32'd2}) begin errors++; $display("FAIL tie_rx_valid: got %0d/%0d want 2/2", rxv_cnt[0] - s_rx0, rxv_cnt[1] - s_rx1); end
        checks++; if ({done_cnt[0] - s_d0, done_cnt[1] - s_d1} !== {32'd1, 32'd1}) begin errors++; $display("FAIL tie_done_cnt: got %0d/%0d want 1/1", done_cnt[0] - s_d0, done_cnt[1] - s_d1); end
        checks++; if (last_rx !== 8'hC2) begin errors++; $display("FAIL tie_rx: got %h want c2", last_rx); end
        checks++; if (viol - s_viol !== 0) begin errors++; $display("FAIL tie_protocol: got %0d violations want 0", viol - s_viol); end
        tx_valid_i = 2'b00;
        $display("test_tie done");
    endtask

    task automatic test_round_robin();
        int s_rx0, s_rx1, s_d1, s_viol, g0;
        bit to;
        @(posedge clk_i); #1;
        s_rx0 = rxv_cnt[0]; s_rx1 = rxv_cnt[1]; s_d1 = done_cnt[1]; s_viol = viol; g0 = grant_n;
        len_i = 8'h23; tx_data_i = 16'h6C33; tx_valid_i = 2'b11; req_i = 2'b01;
        wait_gnt(0, 20, to);
        checks++; if (to !== 1'b0) begin errors++; $display("FAIL rr_grant0: timed out waiting for gnt_o[0]"); end
        repeat (3) @(posedge clk_i);
        #1 req_i = 2'b11;
        wait_done(0, 400, to);
        checks++; if (to !== 1'b0) begin errors++; $display("FAIL rr_done0: timed out waiting for done_o[0]"); end
        wait_gnt(1, 20, to);
        checks++; if (to !== 1'b0) begin errors++; $display("FAIL rr_grant1: timed out waiting for gnt_o[1]"); end
        checks++; if (gnt_o !== 2'b10) begin errors++; $display("FAIL rr_winner: got %b want 10", gnt_o); end
        req_i = 2'b00; len_i = 8'h77;
        wait_done(1, 400, to);
        checks++; if (to !== 1'b0) begin errors++; $display("FAIL rr_done1: timed out waiting for done_o[1]"); end
        @(posedge clk_i); #1;
        checks++; if ({grant_hist[g0[5:0]], grant_hist[6'(g0 + 1)]} !== 2'b01) begin errors++; $display("FAIL rr_order: got %b%b want 01", grant_hist[g0[5:0]], grant_hist[6'(g0 + 1)]); end
        checks++; if ({rxv_cnt[0] - s_rx0, rxv_cnt[1] - s_rx1} !== {32'd3, 32'd2}) begin errors++; $display("FAIL rr_lengths: got %0d/%0d want 3/2", rxv_cnt[0] - s_rx0, rxv_cnt[1] - s_rx1); end
        checks++; if (done_cnt[1] - s_d1 !== 1) begin errors++; $display("FAIL rr_done_cnt: got %0d want 1", done_cnt[1] - s_d1); end
        checks++; if (viol - s_viol !== 0) begin errors++; $display("FAIL rr_protocol: got %0d violations want 0", viol - s_viol); end
        tx_valid_i = 2'b00;
        $display("test_round_robin done");
    endtask

    task automatic test_len16();
        int s_start, s_rx0, s_rx1, s_d0, s_d1;
        bit to;
        @(posedge clk_i); #1;
        s_start = start_cnt; s_rx0 = rxv_cnt[0]; s_rx1 = rxv_cnt[1]; s_d0 = done_cnt[0]; s_d1 = done_cnt[1];
        len_i = 8'h05; tx_data_i = 16'hF000; tx_valid_i = 2'b10; req_i = 2'b10;
        wait_gnt(1, 20, to);
        checks++; if (to !== 1'b0) begin errors++; $display("FAIL len16_grant: timed out waiting for gnt_o[1]"); end
        req_i = 2'b00;
        wait_done(1, 2000, to);
        checks++; if (to !== 1'b0) begin errors++; $display("FAIL len16_done: timed out waiting for done_o[1]"); end
        @(posedge clk_i); #1;
        checks++; if (start_cnt - s_start !== 16) begin errors++; $display("FAIL len16_starts: got %0d want 16", start_cnt - s_start); end
        checks++; if ({rxv_cnt[0] - s_rx0, rxv_cnt[1] - s_rx1} !== {32'd0, 32'd16}) begin errors++; $display("FAIL len16_rx_valid: got %0d/%0d want 0/16", rxv_cnt[0] - s_rx0, rxv_cnt[1] - s_rx1); end
        checks++; if ({done_cnt[0] - s_d0, done_cnt[1] - s_d1} !== {32'd0, 32'd1}) begin errors++; $display("FAIL len16_done_cnt: got %0d/%0d want 0/1", done_cnt[0] - s_d0, done_cnt[1] - s_d1); end
        checks++; if (last_din !== 8'hF0) begin errors++; $display("FAIL len16_din: got %h want f0", last_din); end
        tx_valid_i = 2'b00;
        $display("test_len16 done");
    endtask

    task automatic test_stall();
        int s_start, s_rx0, s_d0, s_viol;
        bit to;
        @(posedge clk_i); #1;
        s_start = start_cnt; s_rx0 = rxv_cnt[0]; s_d0 = done_cnt[0]; s_viol = viol;
        tb_unready = 1'b1; len_i = 8'h01; tx_data_i = 16'h0042; tx_valid_i = 2'b00; req_i = 2'b01;
        wait_gnt(0, 20, to);
        checks++; if (to !== 1'b0) begin errors++; $display("FAIL stall_grant: timed out waiting for gnt_o[0]"); end
        req_i = 2'b00;
        repeat (CS_SETUP + 4) @(posedge clk_i);
        #1 tb_tick = 1'b1;
        @(posedge clk_i);
        #1 tb_tick = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        checks++; if (start_cnt - s_start !== 0) begin errors++; $display("FAIL stall_no_start: got %0d starts want 0", start_cnt - s_start); end
        checks++; if (tx_ready_o !== 2'b00) begin errors++; $display("FAIL stall_ready_low: got %b want 00", tx_ready_o); end
        checks++; if (rxv_cnt[0] - s_rx0 !== 0) begin errors++; $display("FAIL stall_stray_tick: got %0d rx pulses want 0", rxv_cnt[0] - s_rx0); end
        tb_unready = 1'b0;
        wait_ready(0, 20, to);
        checks++; if (to !== 1'b0) begin errors++; $display("FAIL stall_ready: timed out waiting for tx_ready_o[0]"); end
        repeat (5) @(negedge clk_i);
        checks++; if ({tx_ready_o, spi_start_o} !== 3'b010) begin errors++; $display("FAIL stall_wait_valid: got ready/start %b want 010", {tx_ready_o, spi_start_o}); end
        tx_valid_i = 2'b01;
        wait_done(0, 200, to);
        checks++; if (to !== 1'b0) begin errors++; $display("FAIL stall_done: timed out waiting for done_o[0]"); end
        @(posedge clk_i); #1;
        checks++; if (start_cnt - s_start !== 1) begin errors++; $display("FAIL stall_starts: got %0d want 1", start_cnt - s_start); end
        checks++; if ({last_din, last_rx} !== 16'h42DB) begin errors++; $display("FAIL stall_data: got din %h rx %h want 42 db", last_din, last_rx); end
        checks++; if ({rxv_cnt[0] - s_rx0, done_cnt[0] - s_d0} !== {32'd1, 32'd1}) begin errors++; $display("FAIL stall_counts: got rx %0d done %0d want 1 1", rxv_cnt[0] - s_rx0, done_cnt[0] - s_d0); end
        checks++; if (viol - s_viol !== 0) begin errors++; $display("FAIL stall_protocol: got %0d violations want 0", viol - s_viol); end
        tx_valid_i = 2'b00;
        $display("test_stall done");
    endtask

    task automatic test_reset_mid();
        int s_rx0, s_rx1, s_d0, s_d1, s_viol, k;
        bit to;
        @(posedge clk_i); #1;
        s_rx0 = rxv_cnt[0]; s_rx1 = rxv_cnt[1]; s_d0 = done_cnt[0]; s_d1 = done_cnt[1]; s_viol = viol;
        len_i = 8'h04; tx_data_i = 16'h0011; tx_valid_i = 2'b01; req_i = 2'b01;
        wait_gnt(0, 20, to);
        checks++; if (to !== 1'b0) begin errors++; $display("FAIL rmid_grant: timed out waiting for gnt_o[0]"); end
        req_i = 2'b00;
        k = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk_i);
            if (spi_start_o) k++;
            if (k == 2) break;
        end
        checks++; if (k !== 2) begin errors++; $display("FAIL rmid_second_start: got %0d starts want 2", k); end
        #1 rst_ni = 1'b0;
        #1;
        checks++; if ({ss_n_o, gnt_o} !== 4'b1100) begin errors++; $display("FAIL rmid_select: got ss/gnt %b want 1100", {ss_n_o, gnt_o}); end
        checks++; if ({spi_start_o, spi_din_o, rx_data_o} !== 17'h0) begin errors++; $display("FAIL rmid_data: got start %b din %h rx %h want 0 00 00", spi_start_o, spi_din_o, rx_data_o); end
        checks++; if ({tx_ready_o, rx_valid_o, done_o} !== 6'b0) begin errors++; $display("FAIL rmid_handshake: got %b want 0", {tx_ready_o, rx_valid_o, done_o}); end
        repeat (2) @(posedge clk_i);
        #1 rst_ni = 1'b1;
        repeat (15) @(posedge clk_i);
        #1;
        checks++; if ({rxv_cnt[0] - s_rx0, done_cnt[0] - s_d0} !== {32'd1, 32'd0}) begin errors++; $display("FAIL rmid_abort: got rx %0d done %0d want 1 0", rxv_cnt[0] - s_rx0, done_cnt[0] - s_d0); end
        len_i = 8'h10; tx_data_i = 16'h2200; tx_valid_i = 2'b10; req_i = 2'b10;
        wait_gnt(1, 20, to);
        checks++; if (to !== 1'b0) begin errors++; $display("FAIL rmid_regrant: timed out waiting for gnt_o[1]"); end
        req_i = 2'b00;
        wait_done(1, 200, to);
        checks++; if (to !== 1'b0) begin errors++; $display("FAIL rmid_redone: timed out waiting for done_o[1]"); end
        @(posedge clk_i); #1;
        checks++; if ({rxv_cnt[1] - s_rx1, done_cnt[1] - s_d1} !== {32'd1, 32'd1}) begin errors++; $display("FAIL rmid_recover: got rx %0d done %0d want 1 1", rxv_cnt[1] - s_rx1, done_cnt[1] - s_d1); end
        checks++; if (last_rx !== 8'hBB) begin errors++; $display("FAIL rmid_rx: got %h want bb", last_rx); end
        checks++; if (viol - s_viol !== 0) begin errors++; $display("FAIL rmid_protocol: got %0d violations want 0", viol - s_viol); end
        tx_valid_i = 2'b00;
        $display("test_reset_mid done");
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single();
        test_tie();
        test_round_robin();
        test_len16();
        test_stall();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/spi_arbiter.md
SPI_ARBITER -- requirements
Module: spi_arbiter

Interface
REQ-001 SHALL have parameter CS_SETUP, default 2, meaning clock cycles from ss_n assertion to the first spi_start_o (range 1..15).
REQ-002 SHALL have parameter CS_HOLD, default 2, meaning clock cycles from the last spi_done_tick_i to ss_n deassertion (range 1..15).
REQ-003 SHALL have port clk_i  in  1  single system clock; all logic on its rising edge.
REQ-004 SHALL have port rst_ni  in  1  asynchronous active-low reset.
REQ-005 SHALL have port req_i  in  2  bit n = requester n burst request.
REQ-006 SHALL have port len_i  in  8  bits [4n+3:4n] = requester n burst length in bytes, with 0 meaning 16.
REQ-007 SHALL have port gnt_o  out  2  one-hot grant, high for the whole burst.
REQ-008 SHALL have port tx_data_i  in  16  bits [8n+7:8n] = requester n next byte.
REQ-009 SHALL have port tx_valid_i  in  2  byte valid per requester.
REQ-010 SHALL have port tx_ready_o  out  2  byte accept per requester.
REQ-011 SHALL have port rx_data_o  out  8  last received byte, shared by both requesters.
REQ-012 SHALL have port rx_valid_o  out  2  1-cycle pulse, rx_data_o valid for requester n.
REQ-013 SHALL have port done_o  out  2  1-cycle burst-complete pulse per requester.
REQ-014 SHALL have port spi_din_o  out  8  byte to the SPI master core.
REQ-015 SHALL have port spi_start_o  out  1  1-cycle start pulse to the core.
REQ-016 SHALL have port spi_dout_i  in  8  received byte from the core.
REQ-017 SHALL have port spi_done_tick_i  in  1  core byte-complete tick.
REQ-018 SHALL have port spi_ready_i  in  1  core idle.
REQ-019 SHALL have port ss_n_o  out  2  active-low slave selects; bit n belongs to requester n.

Function
REQ-020 SHALL implement FSM states IDLE, SETUP, LOAD, XFER, HOLD; all outputs registered.
REQ-021 IDLE: any req_i high -> grant one requester (REQ-022), latch its len_i into remaining-byte counter, drive gnt_o[n]=1 and ss_n_o[n]=0 next cycle, load setup counter with CS_SETUP, go SETUP.
REQ-022 Arbitration SHALL be round-robin on a last-granted pointer; on a simultaneous request the requester not last granted wins; a single requester always wins.
REQ-023 SETUP: decrement counter; at zero with spi_ready_i=1 go LOAD; wait in SETUP while spi_ready_i=0.
REQ-024 LOAD: tx_ready_o[n]=1 only for the granted n and only while spi_ready_i=1; on handshake (tx_valid_i[n] & tx_ready_o[n]) in cycle t, spi_din_o=byte and spi_start_o=1 in cycle t+1 for exactly one cycle, go XFER.
REQ-025 spi_din_o SHALL hold its value until the next load.
REQ-026 XFER: on spi_done_tick_i, rx_data_o<=spi_dout_i and rx_valid_o[n] pulses 1 cycle; decrement remaining; if remaining was 1 go HOLD, else LOAD.
REQ-027 HOLD: count CS_HOLD cycles, then ss_n_o[n]=1, gnt_o[n]=0, done_o[n] pulses 1 cycle, pointer<=n, go IDLE.
REQ-028 After a burst, ss_n_o SHALL stay all-high for at least 1 cycle (IDLE) before any new grant, including back-to-back grants.
REQ-029 Deassertion of req_i mid-burst SHALL be ignored; the burst completes the latched length.
REQ-030 Changes to len_i after grant SHALL have no effect.
REQ-031 spi_done_tick_i outside XFER SHALL be ignored.
REQ-032 tx_ready_o, rx_valid_o and done_o of the non-granted requester SHALL stay 0.
REQ-033 At most one ss_n_o bit SHALL be low at any time.

Reset
REQ-034 rst_ni low SHALL immediately force state IDLE, ss_n_o=2'b11, gnt_o, tx_ready_o, rx_valid_o, done_o, spi_start_o=0, spi_din_o=0, rx_data_o=0, and pointer=1 (requester 0 wins the first tie).
REQ-035 Reset mid-burst SHALL abort without a done_o pulse; after release the block restarts from IDLE.

Verification
REQ-036 Single byte: req_i=01, len=1, byte 0xA5, core returns 0x3C -> ss_n_o=10, start after CS_SETUP, rx_data_o=0x3C with rx_valid_o=01, done_o=01 after CS_HOLD.
REQ-037 Simultaneous req_i=11 after reset, len=2 each -> requester 0 served first (2 starts), then ≥1 IDLE cycle with ss_n_o=11, then requester 1.
REQ-038 Round-robin: requester 0 holds req continuously and requester 1 raises req mid-burst -> next grant goes to requester 1.
REQ-039 len=0 -> exactly 16 spi_start_o pulses and 16 rx_valid_o pulses, then one done_o pulse.
REQ-040 tx_valid_i delayed 5 cycles in LOAD, and spi_ready_i low at SETUP end -> no start until both are satisfied; start is exactly 1 cycle.
REQ-041 rst_ni asserted in XFER of a 4-byte burst -> outputs immediately at reset values, no done_o pulse, and a new request after release is served normally.
